// File: rtl/channel_router_if.sv
`default_nettype none
// ============================================================================
//  Module      : channel_router_if
//  Description : Telemetry word stream in, FIFO write port and monitor
//                registers out, for the channel router.
//  Revision    : 1.0 - initial release
// ============================================================================
interface channel_router_if #(
    parameter int DW      = 12,
    parameter int AW      = 5,
    parameter int NUM_MON = 2,
    parameter int TAG_EN  = 0
) ();
    localparam int FW = (TAG_EN != 0) ? DW + AW : DW;

    logic [DW-1:0]         data;
    logic                  valid;
    logic [AW-1:0]         address;
    logic                  fifo_full;
    logic                  drop_clr;
    logic [FW-1:0]         fData;
    logic                  fWrEn;
    logic [NUM_MON*DW-1:0] mon_data;
    logic [NUM_MON-1:0]    mon_upd;
    logic [15:0]           drop_cnt;

    modport master (
        output data, valid, address, fifo_full, drop_clr,
        input  fData, fWrEn, mon_data, mon_upd, drop_cnt
    );

    modport slave (
        input  data, valid, address, fifo_full, drop_clr,
        output fData, fWrEn, mon_data, mon_upd, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/channel_router.sv
`default_nettype none
// ============================================================================
//  Module      : channel_router
//  Description : Per-word router: discards masked channels, captures monitor
//                channels, forwards the rest to the FIFO with drop counting.
//  Revision    : 1.0 - initial release
// ============================================================================
module channel_router #(
    parameter int                    DW          = 12,
    parameter int                    AW          = 5,
    parameter logic [2**AW-1:0]      IGNORE_MASK = 32'h0000_0002,
    parameter int                    NUM_MON     = 2,
    parameter logic [NUM_MON*AW-1:0] MON_LIST    = {5'd18, 5'd17},
    parameter int                    TAG_EN      = 0
) (
    input  wire logic       clk,
    input  wire logic       reset,
    channel_router_if.slave bus
);
    localparam int          FW         = (TAG_EN != 0) ? DW + AW : DW;
    localparam logic [15:0] c_drop_max = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROUTE    = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t             r_state;
    logic [AW-1:0]      r_addr;
    logic [DW-1:0]      r_data;

    logic [NUM_MON-1:0] w_match;
    logic [NUM_MON-1:0] w_mon_sel;
    logic               w_found;
    logic               w_ignore;
    logic               w_mon_hit;
    logic               w_drop_event;
    logic [FW-1:0]      w_fifo_word;
    logic [15:0]        w_drop_next;

    generate
        for (genvar gi = 0; gi < NUM_MON; gi++) begin : g_match
            assign w_match[gi] = (MON_LIST[gi*AW +: AW] == r_addr);
        end
    endgenerate

    // Duplicate entries in MON_LIST resolve to the lowest slot.
    always_comb begin
        w_mon_sel = '0;
        w_found   = 1'b0;
        for (int i = 0; i < NUM_MON; i++) begin
            if (w_match[i] && !w_found) begin
                w_mon_sel[i] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    assign w_ignore     = IGNORE_MASK[r_addr];
    assign w_mon_hit    = |w_match;
    assign w_drop_event = (r_state == ROUTE) && !w_ignore && !w_mon_hit && bus.fifo_full;

    generate
        if (TAG_EN != 0) begin : g_tag
            assign w_fifo_word = {r_addr, r_data};
        end else begin : g_plain
            assign w_fifo_word = r_data;
        end
    endgenerate

    // A clear that lands on a drop still counts that drop.
    always_comb begin
        w_drop_next = bus.drop_cnt;
        if (bus.drop_clr) begin
            w_drop_next = w_drop_event ? 16'd1 : 16'd0;
        end else if (w_drop_event && (bus.drop_cnt != c_drop_max)) begin
            w_drop_next = bus.drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_data       <= '0;
            bus.fData    <= '0;
            bus.fWrEn    <= 1'b0;
            bus.mon_data <= '0;
            bus.mon_upd  <= '0;
            bus.drop_cnt <= '0;
        end else begin
            bus.fWrEn    <= 1'b0;
            bus.mon_upd  <= '0;
            bus.drop_cnt <= w_drop_next;
            case (r_state)
                IDLE: begin
                    if (bus.valid) begin
                        r_addr  <= bus.address;
                        r_data  <= bus.data;
                        r_state <= ROUTE;
                    end
                end
                ROUTE: begin
                    if (!w_ignore) begin
                        if (w_mon_hit) begin
                            bus.mon_upd <= w_mon_sel;
                            for (int i = 0; i < NUM_MON; i++) begin
                                if (w_mon_sel[i]) begin
                                    bus.mon_data[i*DW +: DW] <= r_data;
                                end
                            end
                        end else if (!bus.fifo_full) begin
                            bus.fData <= w_fifo_word;
                            bus.fWrEn <= 1'b1;
                        end
                    end
                    r_state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    // One word per strobe, however long valid stays high.
                    if (!bus.valid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_channel_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_channel_router
//  Description : Self-checking bench for channel_router (plain and tagged).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_router;
    localparam int DW = 12;
    localparam int AW = 5;
    localparam int NM = 2;
    localparam int K_NONE = 0;
    localparam int K_FIFO = 1;
    localparam int K_MON  = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            hold;
        logic          full;
        logic          clr;
        int            kind;
        logic [NM-1:0] upd;
        logic [15:0]   drop;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    channel_router_if #(.DW(DW), .AW(AW), .NUM_MON(NM), .TAG_EN(0)) bus ();
    channel_router_if #(.DW(DW), .AW(AW), .NUM_MON(NM), .TAG_EN(1)) bus_t ();

    channel_router #(.DW(DW), .AW(AW), .NUM_MON(NM), .TAG_EN(0)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    channel_router #(.DW(DW), .AW(AW), .NUM_MON(NM), .TAG_EN(1)) dut_t (
        .clk(clk), .reset(reset), .bus(bus_t)
    );

    assign bus_t.data      = bus.data;
    assign bus_t.valid     = bus.valid;
    assign bus_t.address   = bus.address;
    assign bus_t.fifo_full = bus.fifo_full;
    assign bus_t.drop_clr  = bus.drop_clr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0]      q_fifo[$];
    logic [DW+AW-1:0]   q_tag[$];
    logic [NM+DW-1:0]   q_mon[$];

    logic [DW-1:0]      exp_fdata = '0;
    logic [DW+AW-1:0]   exp_tdata = '0;
    logic [DW-1:0]      exp_mon[NM];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every output pulse must match the next queued expectation.
    always @(negedge clk) begin : sb
        logic [DW-1:0]    ef;
        logic [DW+AW-1:0] et;
        logic [NM+DW-1:0] em;
        int               slot;
        if (reset) begin
            if (bus.fWrEn) begin
                if (q_fifo.size() == 0) check("unexpected_fWrEn", 64'd1, 64'd0);
                else begin
                    ef = q_fifo.pop_front();
                    check("fData", 64'(bus.fData), 64'(ef));
                end
            end
            if (bus_t.fWrEn) begin
                if (q_tag.size() == 0) check("unexpected_tag_fWrEn", 64'd1, 64'd0);
                else begin
                    et = q_tag.pop_front();
                    check("tag_fData", 64'(bus_t.fData), 64'(et));
                end
            end
            if (bus.mon_upd != '0) begin
                if (q_mon.size() == 0) check("unexpected_mon_upd", 64'(bus.mon_upd), 64'd0);
                else begin
                    em   = q_mon.pop_front();
                    slot = em[DW] ? 0 : 1;
                    check("mon_upd", 64'(bus.mon_upd), 64'(em[NM+DW-1:DW]));
                    check("mon_slot", 64'(bus.mon_data[slot*DW +: DW]), 64'(em[DW-1:0]));
                end
            end
        end
    end

    task automatic send(input vec_t v);
        bus.address   = v.addr;
        bus.data      = v.data;
        bus.fifo_full = v.full;
        bus.valid     = 1'b1;
        if (v.kind == K_FIFO) begin
            q_fifo.push_back(v.data);
            q_tag.push_back({v.addr, v.data});
            exp_fdata = v.data;
            exp_tdata = {v.addr, v.data};
        end else if (v.kind == K_MON) begin
            q_mon.push_back({v.upd, v.data});
            for (int i = 0; i < NM; i++) if (v.upd[i]) exp_mon[i] = v.data;
        end
        for (int c = 0; c < v.hold; c++) begin
            @(posedge clk); #1;
            bus.drop_clr = (c == 0) ? v.clr : 1'b0;
        end
        bus.valid = 1'b0;
        bus.data  = 12'hEEE;
        repeat (3) begin
            @(posedge clk); #1;
            bus.drop_clr = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag, input logic [15:0] exp_drop);
        check({tag, "_drop_cnt"}, 64'(bus.drop_cnt), 64'(exp_drop));
        check({tag, "_fData_hold"}, 64'(bus.fData), 64'(exp_fdata));
        check({tag, "_tag_fData_hold"}, 64'(bus_t.fData), 64'(exp_tdata));
        check({tag, "_mon_data"}, 64'(bus.mon_data), 64'({exp_mon[1], exp_mon[0]}));
        check({tag, "_quiet"}, 64'({bus.fWrEn, bus.mon_upd}), 64'd0);
    endtask

    vec_t vecs[14];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.valid = 1'b0; bus.data = '0; bus.address = '0;
        bus.fifo_full = 1'b0; bus.drop_clr = 1'b0;
        exp_mon[0] = '0; exp_mon[1] = '0;

        //           addr    data     hold full  clr   kind    upd    drop
        vecs[0]  = '{5'd3,  12'hABC, 2,  1'b0, 1'b0, K_FIFO, 2'b00, 16'd0};
        vecs[1]  = '{5'd1,  12'h777, 1,  1'b0, 1'b0, K_NONE, 2'b00, 16'd0};
        vecs[2]  = '{5'd17, 12'h123, 1,  1'b0, 1'b0, K_MON,  2'b01, 16'd0};
        vecs[3]  = '{5'd18, 12'h456, 3,  1'b0, 1'b0, K_MON,  2'b10, 16'd0};
        vecs[4]  = '{5'd9,  12'h00F, 1,  1'b0, 1'b0, K_FIFO, 2'b00, 16'd0};
        vecs[5]  = '{5'd4,  12'h111, 1,  1'b1, 1'b0, K_NONE, 2'b00, 16'd1};
        vecs[6]  = '{5'd4,  12'h222, 2,  1'b1, 1'b0, K_NONE, 2'b00, 16'd2};
        vecs[7]  = '{5'd4,  12'h333, 1,  1'b1, 1'b0, K_NONE, 2'b00, 16'd3};
        vecs[8]  = '{5'd4,  12'h444, 1,  1'b1, 1'b1, K_NONE, 2'b00, 16'd1};
        vecs[9]  = '{5'd17, 12'h5A5, 1,  1'b1, 1'b0, K_MON,  2'b01, 16'd1};
        vecs[10] = '{5'd1,  12'h000, 1,  1'b1, 1'b0, K_NONE, 2'b00, 16'd1};
        vecs[11] = '{5'd31, 12'hFFF, 20, 1'b0, 1'b0, K_FIFO, 2'b00, 16'd1};
        vecs[12] = '{5'd0,  12'h800, 1,  1'b0, 1'b0, K_FIFO, 2'b00, 16'd1};
        vecs[13] = '{5'd2,  12'h0AA, 1,  1'b0, 1'b0, K_FIFO, 2'b00, 16'd1};

        repeat (3) @(posedge clk);
        #1;
        check_idle("in_reset", 16'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle("after_release", 16'd0);

        for (int i = 0; i < 14; i++) begin
            send(vecs[i]);
            check_idle($sformatf("vec%0d", i), vecs[i].drop);
        end

        // Saturation: preload near the top, then drop twice.
        bus.fifo_full = 1'b1;
        @(negedge clk);
        force bus.drop_cnt = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release bus.drop_cnt;
        @(posedge clk); #1;
        check("preload", 64'(bus.drop_cnt), 64'hFFFE);
        send('{5'd4, 12'h010, 1, 1'b1, 1'b0, K_NONE, 2'b00, 16'hFFFF});
        check_idle("sat_reach", 16'hFFFF);
        send('{5'd4, 12'h020, 1, 1'b1, 1'b0, K_NONE, 2'b00, 16'hFFFF});
        check_idle("sat_hold", 16'hFFFF);

        // drop_clr on its own just zeroes the counter.
        bus.fifo_full = 1'b0;
        bus.drop_clr  = 1'b1;
        @(posedge clk); #1;
        bus.drop_clr  = 1'b0;
        @(posedge clk); #1;
        check_idle("clr_alone", 16'd0);

        // Reset one cycle after valid rise aborts the word.
        bus.address = 5'd3;
        bus.data    = 12'h5AB;
        bus.valid   = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        bus.valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_fdata  = '0;
        exp_tdata  = '0;
        exp_mon[0] = '0;
        exp_mon[1] = '0;
        repeat (5) @(posedge clk);
        #1;
        check_idle("abort", 16'd0);

        check("fifo_queue_drained", 64'(q_fifo.size()), 64'd0);
        check("tag_queue_drained", 64'(q_tag.size()), 64'd0);
        check("mon_queue_drained", 64'(q_mon.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/channel_router.md
# channel_router

Parametrised per-word router for the commutated telemetry stream. Each valid strobe carries one data word and its channel address. The block discards masked channels and captures up to NUM_MON monitor channels (power, temperature, …) into dedicated registers with update strobes. All other channels go to the downstream FIFO with full-flag back-pressure accounting. It sits between the frame deserialiser and the output FIFO and supersedes the single-monitor, fixed-width distributor.

## Interface
- DW, 12, data word width
- AW, 5, channel address width
- IGNORE_MASK, 32'h0000_0002, 2**AW bits; bit k = 1 discards channel k
- NUM_MON, 2, number of monitor channels (1..8)
- MON_LIST, {5'd18,5'd17}, NUM_MON×AW packed list; slot i = bits [i*AW +: AW]
- TAG_EN, 0, 1: FIFO word = {address, data}; 0: FIFO word = data
- FW, derived, DW+AW if TAG_EN else DW

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- data  in  DW  word; stable while valid high
- valid  in  1  word strobe, level; one word per high interval
- address  in  AW  channel of data; stable while valid high
- fifo_full  in  1  downstream FIFO full
- drop_clr  in  1  synchronous clear of drop_cnt
- fData  out  FW  FIFO write data
- fWrEn  out  1  FIFO write enable, one-cycle pulse
- mon_data  out  NUM_MON×DW  monitor registers; slot i = bits [i*DW +: DW]
- mon_upd  out  NUM_MON  per-slot one-cycle update pulse
- drop_cnt  out  16  words lost to fifo_full, saturating

## Operation
- Reset (async, active-low) forces the state to IDLE.
  - Clears fData, fWrEn, mon_data, mon_upd and drop_cnt to 0.
  - Clears the internal latches.
  - Asserting reset mid-word aborts the word; no write or update follows release.
- FSM states: IDLE, ROUTE, WAIT_LOW.
- IDLE: when valid = 1, latch address and data, then go to ROUTE. Otherwise stay.
- ROUTE: classify the latched address in strict priority, then go to WAIT_LOW unconditionally.
  - 1. IGNORE_MASK bit set: no action.
  - 2. Matches MON_LIST slot i: mon_data slot i ← data and mon_upd[i] = 1. If the address appears in several slots, the lowest i wins.
  - 3. Otherwise, fifo_full = 0: fData ← tagged or plain word and fWrEn = 1.
  - 4. Otherwise, fifo_full = 1: no write; drop_cnt increments unless it is already 16'hFFFF.
- WAIT_LOW: stay while valid = 1; go to IDLE on valid = 0. Every strobe is therefore processed exactly once, whatever its length.
- fWrEn and mon_upd are high for exactly one cycle, the cycle after ROUTE.
  - fData holds its value until the next write.
  - mon_data slots hold until their own next update.
- drop_clr: drop_cnt ← 0.
  - If drop_clr coincides with a drop event, drop_cnt ← 1.
  - drop_clr has no other side effects.
- fifo_full is sampled only in ROUTE.

## Timing
- valid sampled high at edge N in IDLE → ROUTE at N+1.
  - fWrEn, mon_upd and drop_cnt change on edge N+1 and are visible in the cycle N+1..N+2.
  - fWrEn and mon_upd clear on edge N+2.
- Latency: valid rise to write or update = 1 clock.
- Minimum valid high time: 1 clock. Minimum valid low time: 1 clock, sampled in WAIT_LOW or IDLE.
- Minimum strobe period: 3 clocks.
- A low gap that falls entirely inside ROUTE (valid low exactly one cycle, at edge N+1 only) is not seen. The adjacent strobes merge and the second word is lost; the source must guarantee the gap.
- data and address are sampled once, at edge N. Changes after that do not affect the word.

## Test plan
- Reset with outputs forced X; release → all outputs 0, state IDLE. Then valid 2 cycles, address 5'd3, data 12'hABC → single fWrEn pulse one clock later, fData = 12'hABC.
- Address 5'd1 (ignored), then address 5'd17 data 12'h123, then address 5'd18 data 12'h456 → no fWrEn; mon_upd = 2'b01 then 2'b10; mon_data = {12'h456, 12'h123}.
- TAG_EN = 1, address 5'd9, data 12'h00F → fData = {5'd9, 12'h00F}; fWrEn 1 cycle.
- fifo_full = 1 for 3 strobes on channel 4 → no fWrEn, drop_cnt = 3; drop_clr asserted in the same cycle as a 4th drop → drop_cnt = 1.
- Preload drop_cnt to 16'hFFFF with fifo_full held; 1 more drop → stays 16'hFFFF.
- valid held high 20 cycles → exactly one fWrEn. Assert reset 1 cycle after valid rise → no fWrEn after release, outputs 0.
